systolic_result_drain: RTL and testbench
========================================

// Module: systolic_result_drain
// PURPOSE
//   Output stage directly downstream of the systolic array and its controller.
//   On the controller's one-cycle done pulse it snapshots all ARRAY_SIZE x ARRAY_SIZE
//   PE accumulators and streams them out one row per beat over a valid/ready interface.
//   Each value is requantised to OUT_W bits with a rounding arithmetic right shift and
//   signed saturation. The array is then free to start the next computation at once.
// PARAMETERS
//   ARRAY_SIZE  4   rows/cols of the PE array (N)
//   ACC_W       32  signed PE accumulator width
//   OUT_W       8   signed output element width (OUT_W <= ACC_W)
//   SHIFT_W     5   width of requantisation shift amount
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous, active-high reset
//   capture    in   1            done pulse from controller; snapshot acc_flat this cycle
//   acc_flat   in   N*N*ACC_W    PE(r,c) accumulator at [(r*N+c)*ACC_W +: ACC_W]
//   shift_amt  in   SHIFT_W      right-shift amount, sampled with capture
//   busy       out  1            high while a snapshot is held or streaming
//   out_valid  out  1            out_data/out_row/out_last are valid
//   out_ready  in   1            consumer accepts the beat when out_valid & out_ready
//   out_data   out  N*OUT_W      row elements; col c at [c*OUT_W +: OUT_W]
//   out_row    out  $clog2(N)    row index of the current beat
//   out_last   out  1            high on the beat for row N-1
//   overrun    out  1            one-cycle pulse: capture dropped while busy
// BEHAVIOUR
//   Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
//   Reset: state=IDLE. busy=0, out_valid=0, out_row=0, out_last=0, overrun=0.
//     out_data=0 and the snapshot register is cleared.
//   Reset mid-stream: all in-flight data is discarded, with no further beats.
//   FSM IDLE:
//     - capture=1 -> latch acc_flat and shift_amt, set row=0, go to STREAM.
//     - busy and out_valid rise in the next cycle (1-cycle latency).
//   FSM STREAM:
//     - out_valid=1. Outputs are held stable while out_valid & !out_ready.
//     - On handshake with row<N-1: row++. The next row is presented in the next cycle.
//     - On handshake with row==N-1: return to IDLE.
//       out_valid and busy drop in the next cycle, unless the capture rule below applies.
//   Capture in STREAM:
//     - Same cycle as the final (row N-1) handshake: the capture is accepted.
//       The snapshot reloads and the FSM stays in STREAM at row 0, with no bubble.
//     - Otherwise: the capture is ignored, the snapshot is unchanged, and overrun
//       pulses high for exactly one cycle in the next cycle.
//   Requantise (per element, combinational from snapshot; the output may be registered):
//     - s = shift_amt. If s==0, y = acc.
//     - Else y = (acc + 2^(s-1)) >>> s, computed in ACC_W+1 bits so there is no wrap.
//     - Rounding is round-half-up toward +inf.
//     - Saturate y to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//     - s >= ACC_W: result is 0 for acc>=0 and -1 for acc<0 (after rounding rule).
//   out_last = (row==N-1) & out_valid. out_row counts 0..N-1 and never wraps mid-stream.
//   out_valid never drops without a handshake once asserted (except on rst).
// TESTING
//   1 Basic: acc(r,c)=r*N+c, shift=0, out_ready=1
//     -> 4 consecutive beats from the cycle after capture.
//     -> row0 data {3,2,1,0}; out_last on row 3; busy then drops.
//   2 Round/saturate: acc={1000,-1000,6,-6}, shift=2
//     -> {127,-128,2,-1} (6+2>>2=2, -6+2>>>2=-1).
//   3 Backpressure: out_ready toggles 1,0,0,1,...
//     -> data and out_row stay stable during stalls; exactly 4 handshakes.
//     -> rows arrive in order 0..3.
//   4 Overrun: capture at row 1 of a stream
//     -> overrun pulses 1 cycle; stream completes with the original data.
//   5 Back-to-back: capture coincides with the row-3 handshake
//     -> the next cycle shows row 0 of new data; out_valid is never deasserted.
//   6 Reset mid-stream: rst during row 2
//     -> next cycle all outputs are 0 and the FSM is IDLE.
//     -> a fresh capture then streams correctly.

Source files
------------

// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - snapshot PE accumulators, requantise, stream one row per beat
// Holds one N x N snapshot; a capture on the final handshake reloads it with no bubble.
module systolic_result_drain #(
   parameter int ARRAY_SIZE = 4,
   parameter int ACC_W      = 32,
   parameter int OUT_W      = 8,
   parameter int SHIFT_W    = 5
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    capture,
   input  logic [ARRAY_SIZE*ARRAY_SIZE*ACC_W-1:0]  acc_flat,
   input  logic [SHIFT_W-1:0]                      shift_amt,
   output logic                                    busy,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [ARRAY_SIZE*OUT_W-1:0]             out_data,
   output logic [$clog2(ARRAY_SIZE)-1:0]           out_row,
   output logic                                    out_last,
   output logic                                    overrun
);
   localparam int N     = ARRAY_SIZE;
   localparam int ROW_W = $clog2(N);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);
   localparam logic signed [ACC_W:0] ONE  = {{ACC_W{1'b0}}, 1'b1};
   localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                   state, state_nx;
   logic [ROW_W-1:0]         row, row_nx;
   logic [N*N*ACC_W-1:0]     snap;
   logic [SHIFT_W-1:0]       shift_q;
   logic                     load, overrun_nx;

   // One extra bit of headroom so adding the rounding constant cannot wrap.
   function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                                input logic [SHIFT_W-1:0] s);
      logic signed [ACC_W:0] w, y;
      w = {acc[ACC_W-1], acc};
      if (s == '0)
         y = w;
      else if (int'(s) >= ACC_W)
         y = acc[ACC_W-1] ? '1 : '0;
      else
         y = (w + (ONE << (s - 1'b1))) >>> s;
      if (y > MAXV)
         y = MAXV;
      else if (y < MINV)
         y = MINV;
      return y[OUT_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         row     <= '0;
         snap    <= '0;
         shift_q <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nx;
         row     <= row_nx;
         overrun <= overrun_nx;
         if (load) begin
            snap    <= acc_flat;
            shift_q <= shift_amt;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      row_nx     = row;
      load       = 1'b0;
      overrun_nx = 1'b0;
      case (state)
         IDLE: begin
            if (capture) begin
               load     = 1'b1;
               row_nx   = '0;
               state_nx = STREAM;
            end
         end
         STREAM: begin
            if (out_ready && row == LAST_ROW) begin
               row_nx = '0;
               if (capture)
                  load = 1'b1;
               else
                  state_nx = IDLE;
            end else begin
               if (out_ready)
                  row_nx = row + 1'b1;
               if (capture)
                  overrun_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy      = (state == STREAM);
   assign out_valid = (state == STREAM);
   assign out_row   = row;
   assign out_last  = out_valid && (row == LAST_ROW);

   always_comb begin
      out_data = '0;
      if (state == STREAM)
         for (int c = 0; c < N; c++)
            out_data[c*OUT_W +: OUT_W] = requant(snap[(int'(row)*N + c)*ACC_W +: ACC_W], shift_q);
   end
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - randomized bench for systolic_result_drain with a behavioural model
module tb_systolic_result_drain;
   localparam int N = 4;
   localparam int ACC_W = 32;
   localparam int OUT_W = 8;
   localparam int SHIFT_W = 5;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   capture = 1'b0;
   logic [N*N*ACC_W-1:0]   acc_flat = '0;
   logic [SHIFT_W-1:0]     shift_amt = '0;
   logic                   busy, out_valid, out_last, overrun;
   logic                   out_ready = 1'b0;
   logic [N*OUT_W-1:0]     out_data;
   logic [1:0]             out_row;

   int errors = 0;
   int checks = 0;

   logic signed [31:0] accs [16];
   logic signed [31:0] nxt  [16];
   int model_s;
   int nxt_s;

   systolic_result_drain #(.ARRAY_SIZE(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
      .clk(clk), .rst(rst), .capture(capture), .acc_flat(acc_flat), .shift_amt(shift_amt),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_last(out_last), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Rounded, saturated value from plain integer arithmetic (>>> on longint is floor division).
   function automatic logic [7:0] ref_q(input logic signed [31:0] a, input int s);
      longint v, y;
      v = a;
      if (s == 0) y = v;
      else if (s >= ACC_W) y = (v < 0) ? -1 : 0;
      else y = (v + (longint'(1) << (s - 1))) >>> s;
      if (y > 127) y = 127;
      if (y < -128) y = -128;
      return y[7:0];
   endfunction

   function automatic logic [31:0] exp_row(input int r);
      logic [31:0] e;
      for (int c = 0; c < N; c++) e[c*8 +: 8] = ref_q(accs[r*N + c], model_s);
      return e;
   endfunction

   task automatic drive_acc(input bit use_nxt);
      for (int i = 0; i < N*N; i++) acc_flat[i*32 +: 32] = use_nxt ? nxt[i] : accs[i];
      shift_amt = SHIFT_W'(use_nxt ? nxt_s : model_s);
   endtask

   task automatic rand_fill(input bit to_nxt);
      for (int i = 0; i < N*N; i++) begin
         logic signed [31:0] v;
         if ($urandom_range(0, 3) == 0) v = $urandom;
         else v = $signed($urandom_range(0, 4000)) - 2000;
         if (to_nxt) nxt[i] = v; else accs[i] = v;
      end
      if (to_nxt) nxt_s = $urandom_range(0, 31); else model_s = $urandom_range(0, 31);
   endtask

   // Called at a negedge; leaves the first beat visible at the following negedge.
   task automatic do_capture();
      capture = 1'b1;
      drive_acc(1'b0);
      @(negedge clk);
      capture = 1'b0;
   endtask

   // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
   task automatic drain(input int mode, input int cap_row, input bit accept, input int total);
      int beat = 0;
      int cyc = 0;
      int rcnt = 0;
      bit ov_exp = 1'b0;
      bit cap_done = 1'b0;
      logic r;
      while (beat < total && cyc < 300) begin
         checks++;
         if (overrun !== ov_exp) begin
            errors++; $display("FAIL overrun beat=%0d got=%b want=%b", beat, overrun, ov_exp);
         end
         ov_exp = 1'b0;
         capture = 1'b0;
         if (mode == 0) begin
            checks++;
            if (out_valid !== 1'b1) begin
               errors++; $display("FAIL valid_continuous beat=%0d got=%b want=1", beat, out_valid);
            end
         end
         case (mode)
            0: r = 1'b1;
            1: r = (rcnt % 4 == 0) || (rcnt % 4 == 3);
            default: r = 1'($urandom_range(0, 1));
         endcase
         rcnt++;
         if (out_valid === 1'b1) begin
            checks += 4;
            if (out_row !== 2'(beat % 4)) begin
               errors++; $display("FAIL row got=%0d want=%0d", out_row, beat % 4);
            end
            if (out_data !== exp_row(beat % 4)) begin
               errors++; $display("FAIL data row=%0d got=%h want=%h", beat % 4, out_data, exp_row(beat % 4));
            end
            if (out_last !== (beat % 4 == 3)) begin
               errors++; $display("FAIL last row=%0d got=%b", beat % 4, out_last);
            end
            if (busy !== 1'b1) begin
               errors++; $display("FAIL busy_stream got=%b want=1", busy);
            end
            if (!cap_done && cap_row >= 0 && beat % 4 == cap_row) begin
               capture = 1'b1;
               drive_acc(1'b1);
               cap_done = 1'b1;
               if (accept) r = 1'b1;
               else ov_exp = 1'b1;
            end
            if (r) begin
               beat++;
               if (accept && cap_done && beat == 4) begin
                  accs = nxt;
                  model_s = nxt_s;
               end
            end
         end
         out_ready = r;
         @(negedge clk);
         cyc++;
      end
      capture = 1'b0;
      out_ready = 1'b0;
      checks += 4;
      if (cyc >= 300) begin
         errors++; $display("FAIL drain_timeout beats=%0d want=%0d", beat, total);
      end
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL valid_after got=%b want=0", out_valid);
      end
      if (busy !== 1'b0) begin
         errors++; $display("FAIL busy_after got=%b want=0", busy);
      end
      if (overrun !== ov_exp) begin
         errors++; $display("FAIL overrun_after got=%b want=%b", overrun, ov_exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks += 6;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      if (out_row !== 2'd0) begin errors++; $display("FAIL reset_row got=%0d want=0", out_row); end
      if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b want=0", out_last); end
      if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
      if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", out_data); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      for (int i = 0; i < N*N; i++) accs[i] = i;
      model_s = 0;
      do_capture();
      checks++;
      if (out_data !== 32'h03020100) begin
         errors++; $display("FAIL basic_row0 got=%h want=03020100", out_data);
      end
      drain(0, -1, 1'b0, 4);
   endtask

   task automatic test_round_sat();
      rand_fill(1'b0);
      accs[0] = 1000; accs[1] = -1000; accs[2] = 6; accs[3] = -6;
      accs[4] = 32'sh7fffffff; accs[5] = 32'sh80000000; accs[6] = 2; accs[7] = -2;
      model_s = 2;
      do_capture();
      checks++;
      if (out_data !== {8'hff, 8'h02, 8'h80, 8'h7f}) begin
         errors++; $display("FAIL round_sat_row0 got=%h want=ff02807f", out_data);
      end
      drain(0, -1, 1'b0, 4);
      model_s = 31;
      do_capture();
      drain(0, -1, 1'b0, 4);
   endtask

   task automatic test_backpressure();
      rand_fill(1'b0);
      do_capture();
      drain(1, -1, 1'b0, 4);
   endtask

   task automatic test_overrun();
      rand_fill(1'b0);
      rand_fill(1'b1);
      do_capture();
      drain(1, 1, 1'b0, 4);
   endtask

   task automatic test_back_to_back();
      rand_fill(1'b0);
      rand_fill(1'b1);
      do_capture();
      drain(0, 3, 1'b1, 8);
   endtask

   task automatic test_reset_mid();
      rand_fill(1'b0);
      do_capture();
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (out_row !== 2'd2) begin errors++; $display("FAIL mid_row got=%0d want=2", out_row); end
      rst = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks += 5;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_reset_valid got=%b%b want=00", out_valid, busy);
      end
      if (out_row !== 2'd0) begin errors++; $display("FAIL mid_reset_row got=%0d want=0", out_row); end
      if (out_last !== 1'b0) begin errors++; $display("FAIL mid_reset_last got=%b want=0", out_last); end
      if (overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_overrun got=%b want=0", overrun); end
      if (out_data !== '0) begin errors++; $display("FAIL mid_reset_data got=%h want=0", out_data); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_idle got=%b want=0", out_valid); end
      rand_fill(1'b0);
      do_capture();
      drain(0, -1, 1'b0, 4);
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++) begin
         rand_fill(1'b0);
         do_capture();
         drain(2, -1, 1'b0, 4);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_round_sat();
      test_backpressure();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
